// File: rtl/fir_result_sink.sv
// Output sink for the serial FIR: rounds/saturates each result to DOUT_W bits and
// buffers it in a first-word-fall-through FIFO presented as a valid/ready stream.
module fir_result_sink #(
  parameter int DIN_W  = 29,
  parameter int DOUT_W = 12,
  parameter int SHIFT  = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic [DIN_W-1:0]         yout,
  output logic                     m_valid,
  output logic [DOUT_W-1:0]        m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sat,
  output logic                     drop,
  output logic [7:0]               drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int QW = DIN_W + 1;

  localparam logic signed [QW-1:0] RND   = QW'(1) << (SHIFT - 1);
  localparam logic signed [QW-1:0] Q_MAX = QW'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [QW-1:0] Q_MIN = ~Q_MAX;
  localparam logic [DOUT_W-1:0]    D_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0]    D_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

  logic [DIN_W-1:0]        yout_r;
  logic                    s1_v;
  logic                    s2_v;
  logic                    s2_sat;
  logic [DOUT_W-1:0]       s2_data;

  logic signed [QW-1:0]    t;
  logic signed [QW-1:0]    q;
  logic [DOUT_W-1:0]       scaled;
  logic                    scaled_sat;

  logic [DOUT_W-1:0]       mem [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;

  logic                    pop;
  logic                    full;
  logic                    room;
  logic                    push;

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    t          = $signed({yout_r[DIN_W-1], yout_r}) + RND;
    q          = t >>> SHIFT;
    scaled     = q[DOUT_W-1:0];
    scaled_sat = 1'b0;
    if (q > Q_MAX) begin
      scaled     = D_MAX;
      scaled_sat = 1'b1;
    end else if (q < Q_MIN) begin
      scaled     = D_MIN;
      scaled_sat = 1'b1;
    end
  end

  assign m_valid = (level != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign pop     = m_valid & m_ready;
  assign full    = (level == LW'(DEPTH));
  assign room    = ~full | pop;
  assign push    = s2_v & room;

  // Datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (rdy) yout_r <= yout;
    s2_data <= scaled;
    s2_sat  <= scaled_sat;
    if (push) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      sat      <= 1'b0;
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      s1_v <= rdy;
      s2_v <= s1_v;
      drop <= s2_v & ~room;
      if (s2_v && s2_sat) sat <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (s2_v && !room && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fir_result_sink.sv
// Randomized and directed bench for fir_result_sink against a queue-based model
// of the round/saturate/FIFO behaviour.
module tb_fir_result_sink;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic [28:0] yout = '0;
  logic        m_valid;
  logic [11:0] m_data;
  logic        m_ready = 1'b0;
  logic [3:0]  level;
  logic        sat;
  logic        drop;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  fir_result_sink #(.DIN_W(29), .DOUT_W(12), .SHIFT(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst), .rdy(rdy), .yout(yout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .level(level), .sat(sat), .drop(drop), .drop_cnt(drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int drop_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round half up by floor division, then clamp to the 12-bit signed range.
  function automatic void scale(input logic [28:0] y, output int v, output bit s);
    longint yv, num, qq;
    yv  = $signed(y);
    num = yv + 32768;
    qq  = num / 65536;
    if (num < 0 && (num % 65536) != 0) qq = qq - 1;
    s = 1'b0;
    if (qq > 2047) begin
      qq = 2047; s = 1'b1;
    end else if (qq < -2048) begin
      qq = -2048; s = 1'b1;
    end
    v = int'(qq);
  endfunction

  typedef struct {
    int due;
    int val;
    bit s;
  } flight_t;

  flight_t infl[$];
  int      fq[$];
  int      cyc = 0;
  bit      exp_sat = 1'b0;
  bit      exp_drop = 1'b0;
  int      exp_dcnt = 0;

  // Model: a sample captured at cycle c reaches the FIFO at cycle c+2.
  initial begin
    flight_t it;
    bit pop, room;
    int v;
    bit s;
    forever begin
      @(posedge clk);
      if (rst) begin
        infl.delete();
        fq.delete();
        exp_sat  = 1'b0;
        exp_drop = 1'b0;
        exp_dcnt = 0;
      end else begin
        pop      = (fq.size() > 0) && m_ready;
        room     = (fq.size() < DEPTH) || pop;
        exp_drop = 1'b0;
        if (pop) void'(fq.pop_front());
        if (infl.size() > 0 && infl[0].due == cyc) begin
          it = infl.pop_front();
          if (it.s) exp_sat = 1'b1;
          if (room) fq.push_back(it.val);
          else begin
            exp_drop = 1'b1;
            if (exp_dcnt < 255) exp_dcnt++;
          end
        end
        if (rdy) begin
          scale(yout, v, s);
          it.due = cyc + 2;
          it.val = v;
          it.s   = s;
          infl.push_back(it);
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_valid", longint'(m_valid), longint'(fq.size() > 0));
        check("m_data", longint'($signed(m_data)), (fq.size() > 0) ? longint'(fq[0]) : 0);
        check("level", longint'(level), longint'(fq.size()));
        check("sat", longint'(sat), longint'(exp_sat));
        check("drop", longint'(drop), longint'(exp_drop));
        check("drop_cnt", longint'(drop_cnt), longint'(exp_dcnt));
      end
      if (drop) drop_seen++;
    end
  end

  task automatic pulse(input logic [28:0] v);
    rdy  = 1'b1;
    yout = v;
    @(negedge clk);
    rdy  = 1'b0;
    yout = 29'($urandom);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [28:0] rand_yout();
    logic [31:0] r;
    int k, sv;
    case ($urandom_range(0, 3))
      0: r = $urandom;
      1: begin sv = int'($urandom_range(0, 268435455)) - 134217728; r = sv; end
      2: begin
        k  = int'($urandom_range(0, 4095)) - 2048;
        sv = k * 65536 + 32768 - int'($urandom_range(0, 1));
        r  = sv;
      end
      default: begin sv = int'($urandom_range(0, 1048576)) - 524288; r = sv; end
    endcase
    return r[28:0];
  endfunction

  initial begin
    int p;
    // Reset with rdy toggling.
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdy = ~rdy; yout = 29'($urandom);
      @(negedge clk);
      check("rst_m_valid", longint'(m_valid), 0);
      check("rst_m_data", longint'(m_data), 0);
      check("rst_level", longint'(level), 0);
      check("rst_dcnt", longint'(drop_cnt), 0);
    end
    rdy = 1'b0;
    rst = 1'b0;
    wait_n(5);
    check("idle_m_valid", longint'(m_valid), 0);

    // Rounding.
    m_ready = 1'b1;
    pulse(29'h0008000); wait_n(2);
    check("round_a", longint'(m_data), 12'h001);
    check("round_a_v", longint'(m_valid), 1);
    pulse(29'h0007FFF); wait_n(2);
    check("round_b", longint'(m_data), 12'h000);
    check("round_b_v", longint'(m_valid), 1);
    pulse(29'h1FFF0000); wait_n(2);
    check("round_c", longint'(m_data), 12'hFFF);
    check("round_sat0", longint'(sat), 0);

    // Saturation.
    pulse(29'h0FFFFFFF); wait_n(2);
    check("sat_pos", longint'(m_data), 12'h7FF);
    check("sat_set", longint'(sat), 1);
    pulse(29'h10000000); wait_n(2);
    check("sat_neg", longint'(m_data), 12'h800);
    check("sat_sticky", longint'(sat), 1);
    wait_n(3);

    // Fill and drop.
    m_ready = 1'b0;
    drop_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      pulse(29'(k * 65536));
      wait_n(7);
    end
    check("fill_level", longint'(level), 8);
    check("fill_drops", longint'(drop_seen), 2);
    check("fill_dcnt", longint'(drop_cnt), 2);
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("drain_data", longint'(m_data), longint'(k));
      @(negedge clk);
    end
    check("drain_empty", longint'(m_valid), 0);

    // Push and pop together at full, across the pointer wrap.
    m_ready = 1'b0;
    for (int k = 11; k <= 18; k++) begin
      pulse(29'(k * 65536));
      wait_n(1);
    end
    wait_n(3);
    check("full_level", longint'(level), 8);
    drop_seen = 0;
    pulse(29'(19 * 65536));
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("pp_level", longint'(level), 8);
    check("pp_drop", longint'(drop), 0);
    wait_n(2);
    check("pp_nodrop", longint'(drop_seen), 0);
    check("pp_dcnt", longint'(drop_cnt), 2);
    m_ready = 1'b1;
    for (int k = 12; k <= 19; k++) begin
      check("pp_order", longint'(m_data), longint'(k));
      @(negedge clk);
    end

    // Reset mid-stream.
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) pulse(29'(k * 65536));
    wait_n(3);
    check("mid_level", longint'(level), 5);
    pulse(29'(7 * 65536));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("mid_level0", longint'(level), 0);
      check("mid_valid0", longint'(m_valid), 0);
      @(negedge clk);
    end

    // Randomized traffic with varying backpressure and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      p = int'($urandom_range(5, 100));
      for (int i = 0; i < 500; i++) begin
        rst     = ($urandom_range(0, 399) == 0);
        rdy     = ($urandom_range(0, 1) == 1);
        yout    = rand_yout();
        m_ready = (int'($urandom_range(1, 100)) <= p);
        @(negedge clk);
      end
    end
    rst = 1'b0; rdy = 1'b0; m_ready = 1'b1;
    wait_n(12);
    check("end_empty", longint'(m_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_result_sink.md
# fir_result_sink

Output-side consumer for the serial FIR filter. It captures each `yout` sample when the filter pulses `rdy`, rounds and saturates the 29-bit result to a 12-bit signed sample, and buffers it in a small first-word-fall-through FIFO. It presents the samples downstream on a valid/ready stream. The block sits between the FIR (one result per 8 clocks) and any slower or bursty consumer such as a DAC packer or UART dumper, and it reports saturation and overflow.

## Interface

- `DIN_W`, 29: FIR result width; signed two's complement.
- `DOUT_W`, 12: output sample width; signed.
- `SHIFT`, 16: arithmetic right shift applied before saturation; must be ≥1.
- `DEPTH`, 8: FIFO depth; must be a power of 2, ≥2.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset. Despite the codebase port name, 1 = reset, sampled on `clk`.
- `rdy`  in  1  FIR result strobe; one-cycle pulse.
- `yout`  in  DIN_W  FIR result; valid only while `rdy`=1.
- `m_valid`  out  1  FIFO head valid.
- `m_data`  out  DOUT_W  FIFO head sample.
- `m_ready`  in  1  downstream accept.
- `level`  out  log2(DEPTH)+1  current FIFO occupancy.
- `sat`  out  1  sticky flag: at least one sample saturated since reset.
- `drop`  out  1  one-cycle pulse when a sample is discarded because the FIFO is full.
- `drop_cnt`  out  8  saturating count of dropped samples; holds at 255.

## Operation

- **Stage 1 (capture):** when `rdy`=1, register `yout` and set `s1_v`. When `rdy`=0, clear `s1_v`. `yout` is ignored when `rdy`=0.
- **Stage 2 (scale):** compute `t = sext(yout_r, DIN_W+1) + 2^(SHIFT-1)`, then `q = t >>> SHIFT`. This is round-half-up with no overflow in the add.
  - If q > 2^(DOUT_W-1)-1, output 2047 and set `sat`.
  - If q < -2^(DOUT_W-1), output -2048 and set `sat`.
  - Otherwise output q[DOUT_W-1:0].
  - Register the result as `s2_data` with `s2_v` = previous `s1_v`.
- **FIFO write:** when `s2_v`=1 and the FIFO has room, write `s2_data`. Room exists when `level` < DEPTH, or when `level` = DEPTH and a pop occurs in the same cycle.
- **Drop:** when `s2_v`=1 and there is no room, discard the sample, pulse `drop`, and increment `drop_cnt` (saturating).
- **FIFO read:** a pop occurs when `m_valid`=1 and `m_ready`=1. `m_data` always shows the head entry; it is 0 when the FIFO is empty.
- **Level update:**
  - push without pop: +1
  - pop without push: -1
  - push and pop together: unchanged
- **Pointers:** read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- **Reset:** while `rst_n`=1, clear `s1_v`, `s2_v`, both pointers, `level`, `sat`, `drop`, and `drop_cnt`. Reset mid-operation discards in-flight and stored samples. No output toggles in the cycle after reset deasserts.

## Timing

- **Reset values:** `m_valid`=0, `m_data`=0, `level`=0, `sat`=0, `drop`=0, `drop_cnt`=0.
- **Latency with an empty FIFO:** `rdy` sampled high at edge N gives `m_valid`=1 after edge N+2, with `level`=1.
- **Throughput:** one sample per clock sustained. Back-to-back `rdy` pulses are legal even though the FIR produces one every 8 clocks.
- **`m_ready` dependency:** `m_valid` never depends combinationally on `m_ready`. `m_data` and `m_valid` are stable until popped.
- **Push and pop at `level`=DEPTH:** both succeed, and `drop` stays 0.
- **Flag timing:** `drop` and the `sat` set both occur in the same cycle the sample would be written.

## Test plan

- **Reset:** assert `rst_n` for 3 clocks with `rdy` toggling → all outputs 0. Release, idle 5 clocks → `m_valid`=0.
- **Rounding:** feed `yout` = 29'h0008000, 29'h0007FFF, 29'h1FFF0000 with `m_ready`=1 → `m_data` = 12'h001, 12'h000, 12'hFFF, each 2 clocks after its `rdy`; `sat`=0.
- **Saturation:** `yout` = 29'h0FFFFFFF → 12'h7FF. Then 29'h10000000 → 12'h800. `sat`=1 after the first and stays 1.
- **Fill and drop:** `m_ready`=0, 10 `rdy` pulses spaced 8 clocks apart with values 1..10 (pre-shift ×65536) → `level`=8, `drop` pulses twice, `drop_cnt`=2. Draining yields 1..8 in order.
- **Simultaneous push/pop at full:** `level`=8 with `m_ready`=1 during a write → `level` stays 8, `drop`=0, and output order is preserved across the pointer wrap.
- **Reset mid-stream:** assert `rst_n` with `level`=5 and a sample in stage 2 → after release, `level`=0, `m_valid`=0, and no stale sample appears.
